// File: rtl/perf_counter_unit.sv
// perf_counter_unit: bank of NUM_CNTR event counters with freeze, clear,
// atomic snapshot into readable shadows and sticky overflow flags, accessed
// through a 32-bit MMIO slave port with a one-cycle read latency.
// Optional feature macro: PERF_CNTR_IRQ_EN adds IRQ_MASK at 0x0C and irq_o.
module perf_counter_unit #(
   parameter int NUM_CNTR = 5,
   parameter int CNTR_W   = 64,
   parameter int SATURATE = 0,
   parameter int ADDR_W   = 8
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic [NUM_CNTR-1:0] evt_i,
   input  logic                halt_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic                wvalid_i,
   input  logic [31:0]         wdata_i,
   input  logic                rreq_i,
   output logic [31:0]         rdata_o,
   output logic                rvalid_o
`ifdef PERF_CNTR_IRQ_EN
   ,
   output logic                irq_o
`endif
);

   localparam logic [CNTR_W-1:0] CNT_ONE = CNTR_W'(1);
   localparam logic [31:0]       INFO    = {16'(CNTR_W), 8'(SATURATE), 8'(NUM_CNTR)};

   logic [CNTR_W-1:0]   cnt_q    [NUM_CNTR];
   logic [CNTR_W-1:0]   cnt_n    [NUM_CNTR];
   logic [CNTR_W-1:0]   shadow_q [NUM_CNTR];
   logic [NUM_CNTR-1:0] status_q;
   logic [NUM_CNTR-1:0] status_n;
   logic [NUM_CNTR-1:0] sat_q;
   logic [NUM_CNTR-1:0] sat_n;
   logic [NUM_CNTR-1:0] ovf;
   logic [NUM_CNTR-1:0] w1c_mask;
   logic                en_q;
   logic [31:0]         word;
   logic                wr_ctrl;
   logic                clr;
   logic                snap;
   logic                wr_status;
   logic [31:0]         rd_data;
`ifdef PERF_CNTR_IRQ_EN
   logic [NUM_CNTR-1:0] irq_mask_q;
   logic                wr_mask;
`endif

   // Selects the low or high 32-bit half of a shadow, zero-extended.
   function automatic logic [31:0] shadow_word(input logic [CNTR_W-1:0] v, input logic hi);
      logic [63:0] ext;
      ext = 64'(v);
      return hi ? ext[63:32] : ext[31:0];
   endfunction

   assign word      = 32'(addr_i[ADDR_W-1:2]);
   assign wr_ctrl   = wvalid_i && (word == 32'd0);
   assign clr       = wr_ctrl && wdata_i[1];
   assign snap      = wr_ctrl && wdata_i[2];
   assign wr_status = wvalid_i && (word == 32'd1);
   assign w1c_mask  = wr_status ? wdata_i[NUM_CNTR-1:0] : '0;
   assign status_n  = (status_q & ~w1c_mask) | ovf;
`ifdef PERF_CNTR_IRQ_EN
   assign wr_mask   = wvalid_i && (word == 32'd3);
`endif

   // Next counter values; sat_q remembers that a saturating counter already
   // reported its overflow, so software clearing the flag keeps it cleared.
   always_comb begin
      for (int i = 0; i < NUM_CNTR; i++) begin
         cnt_n[i] = cnt_q[i];
         sat_n[i] = sat_q[i];
         ovf[i]   = 1'b0;
         if (clr) begin
            cnt_n[i] = '0;
            sat_n[i] = 1'b0;
         end else if (en_q && !halt_i && evt_i[i]) begin
            if (&cnt_q[i]) begin
               ovf[i]   = (SATURATE == 0) || !sat_q[i];
               sat_n[i] = (SATURATE != 0);
               cnt_n[i] = (SATURATE != 0) ? cnt_q[i] : '0;
            end else begin
               cnt_n[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // Counters, shadows, control and status state.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
         status_q <= '0;
         sat_q    <= '0;
         en_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            cnt_q[i] <= cnt_n[i];
            if (snap) shadow_q[i] <= cnt_q[i];
         end
         status_q <= status_n;
         sat_q    <= sat_n;
         if (wr_ctrl) en_q <= wdata_i[0];
      end
   end

   // Read mux over pre-edge state, so a same-cycle write is not visible.
   always_comb begin
      rd_data = '0;
      case (word)
         32'd0: rd_data = {31'b0, en_q};
         32'd1: rd_data = 32'(status_q);
         32'd2: rd_data = INFO;
`ifdef PERF_CNTR_IRQ_EN
         32'd3: rd_data = 32'(irq_mask_q);
`endif
         default: begin
            for (int i = 0; i < NUM_CNTR; i++) begin
               if (word == 32'(4 + 2 * i)) rd_data = shadow_word(shadow_q[i], 1'b0);
               if (word == 32'(5 + 2 * i)) rd_data = shadow_word(shadow_q[i], 1'b1);
            end
         end
      endcase
   end

   // Registered read response; data holds between reads.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
      end else begin
         rvalid_o <= rreq_i;
         if (rreq_i) rdata_o <= rd_data;
      end
   end

`ifdef PERF_CNTR_IRQ_EN
   // Interrupt mask register and registered level interrupt.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         irq_mask_q <= '0;
         irq_o      <= 1'b0;
      end else begin
         if (wr_mask) irq_mask_q <= wdata_i[NUM_CNTR-1:0];
         irq_o <= |(status_q & irq_mask_q);
      end
   end
`endif

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: three instances share the write
// bus (64-bit wrap, 8-bit wrap, 8-bit saturate); each has its own event and
// read-request lines. Reads push an expectation; a monitor pops on rvalid_o.
module tb_perf_counter_unit;

   typedef struct {
      int          inst;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        halt;
   logic [7:0]  addr;
   logic        wvalid;
   logic [31:0] wdata;
   logic [4:0]  evt [3];
   logic [2:0]  rreq;
   logic [31:0] rdata [3];
   logic [2:0]  rvalid;
`ifdef PERF_CNTR_IRQ_EN
   logic [2:0]  irq;
`endif

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   perf_counter_unit #(.NUM_CNTR(5), .CNTR_W(64), .SATURATE(0), .ADDR_W(8)) u0 (
      .clk_i(clk), .rst_n(rst_n), .evt_i(evt[0]), .halt_i(halt), .addr_i(addr),
      .wvalid_i(wvalid), .wdata_i(wdata), .rreq_i(rreq[0]), .rdata_o(rdata[0]),
      .rvalid_o(rvalid[0])
`ifdef PERF_CNTR_IRQ_EN
      , .irq_o(irq[0])
`endif
   );

   perf_counter_unit #(.NUM_CNTR(5), .CNTR_W(8), .SATURATE(0), .ADDR_W(8)) u1 (
      .clk_i(clk), .rst_n(rst_n), .evt_i(evt[1]), .halt_i(halt), .addr_i(addr),
      .wvalid_i(wvalid), .wdata_i(wdata), .rreq_i(rreq[1]), .rdata_o(rdata[1]),
      .rvalid_o(rvalid[1])
`ifdef PERF_CNTR_IRQ_EN
      , .irq_o(irq[1])
`endif
   );

   perf_counter_unit #(.NUM_CNTR(5), .CNTR_W(8), .SATURATE(1), .ADDR_W(8)) u2 (
      .clk_i(clk), .rst_n(rst_n), .evt_i(evt[2]), .halt_i(halt), .addr_i(addr),
      .wvalid_i(wvalid), .wdata_i(wdata), .rreq_i(rreq[2]), .rdata_o(rdata[2]),
      .rvalid_o(rvalid[2])
`ifdef PERF_CNTR_IRQ_EN
      , .irq_o(irq[2])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every read response is matched against the oldest expectation.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rvalid[k]) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_rvalid inst%0d: got %08h, required no response", k, rdata[k]);
            end else begin
               exp_t e;
               e = sb.pop_front();
               n_cmp++;
               if (e.inst != k || rdata[k] !== e.exp) begin
                  n_fail++;
                  $display("FAIL %s: inst%0d got %08h, required inst%0d %08h",
                           e.name, k, rdata[k], e.inst, e.exp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, required %08h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      addr   = a;
      wdata  = d;
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
   endtask

   task automatic rd(input int k, input logic [7:0] a, input logic [31:0] exp, input string nm);
      exp_t e;
      e.inst = k;
      e.exp  = exp;
      e.name = nm;
      sb.push_back(e);
      addr    = a;
      rreq[k] = 1'b1;
      tick();
      rreq[k] = 1'b0;
   endtask

   // Read and write the same address in one cycle; read sees pre-write value.
   task automatic rw(input int k, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
      exp_t e;
      e.inst = k;
      e.exp  = exp;
      e.name = nm;
      sb.push_back(e);
      addr    = a;
      wdata   = d;
      wvalid  = 1'b1;
      rreq[k] = 1'b1;
      tick();
      wvalid  = 1'b0;
      rreq[k] = 1'b0;
   endtask

   task automatic pulse(input int k, input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         evt[k][ch] = 1'b1;
         tick();
      end
      evt[k][ch] = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      halt   = 1'b0;
      addr   = '0;
      wvalid = 1'b0;
      wdata  = '0;
      rreq   = '0;
      for (int k = 0; k < 3; k++) evt[k] = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state and INFO for each configuration
      chk("rst_rvalid", {29'b0, rvalid}, 32'h0);
      chk("rst_rdata0", rdata[0], 32'h0);
      rd(0, 8'h08, 32'h0040_0005, "info_u0");
      rd(1, 8'h08, 32'h0008_0005, "info_u1");
      rd(2, 8'h08, 32'h0008_0105, "info_u2");
      rd(0, 8'h00, 32'h0, "ctrl_rst");
      rd(0, 8'h04, 32'h0, "status_rst");
      for (int i = 0; i < 5; i++) begin
         rd(0, 8'(8'h10 + 8 * i), 32'h0, "shadow_lo_rst");
         rd(0, 8'(8'h14 + 8 * i), 32'h0, "shadow_hi_rst");
      end
      rd(0, 8'h0C, 32'h0, "offset_0c_rst");
      rd(0, 8'h60, 32'h0, "unmapped");

      // Counting with halt: 10 events, 3 frozen -> 7
      wr(8'h00, 32'h1);
      for (int i = 0; i < 10; i++) begin
         evt[0][2] = 1'b1;
         halt      = (i >= 3 && i < 6);
         tick();
      end
      evt[0][2] = 1'b0;
      halt      = 1'b0;
      wr(8'h00, 32'h5);
      rd(0, 8'h20, 32'h7, "halt_lo2");
      rd(0, 8'h24, 32'h0, "halt_hi2");
      rd(0, 8'h10, 32'h0, "halt_lo0");
      rd(0, 8'h18, 32'h0, "halt_lo1");
      rd(0, 8'h28, 32'h0, "halt_lo3");
      rd(0, 8'h30, 32'h0, "halt_lo4");
      rd(0, 8'h00, 32'h1, "ctrl_selfclr");

      // 8-bit wrap: 257 events -> 1 with sticky flag
      pulse(1, 0, 257);
      wr(8'h00, 32'h5);
      rd(1, 8'h10, 32'h1, "wrap_lo0");
      rd(1, 8'h14, 32'h0, "wrap_hi0");
      rw(1, 8'h04, 32'h1, 32'h1, "status_rw");
      rd(1, 8'h04, 32'h0, "status_w1c");

      // Overflow coinciding with W1C of the same bit keeps the flag
      pulse(1, 1, 256);
      pulse(1, 1, 255);
      evt[1][1] = 1'b1;
      wr(8'h04, 32'h2);
      evt[1][1] = 1'b0;
      rd(1, 8'h04, 32'h2, "ovf_beats_w1c");
      wr(8'h04, 32'h2);

      // 8-bit saturate: holds 0xFF, flag not re-set after clear
      pulse(2, 1, 300);
      wr(8'h00, 32'h5);
      rd(2, 8'h18, 32'hFF, "sat_lo1");
      rd(2, 8'h04, 32'h2, "sat_status");
      wr(8'h04, 32'h2);
      pulse(2, 1, 5);
      rd(2, 8'h04, 32'h0, "sat_no_reflag");
      evt[2][1] = 1'b1;
      wr(8'h00, 32'h7);
      evt[2][1] = 1'b0;
      rd(2, 8'h18, 32'hFF, "clrsnap_old");
      wr(8'h00, 32'h5);
      rd(2, 8'h18, 32'h0, "clrsnap_zero");
      rd(2, 8'h00, 32'h1, "clr_keeps_en");

      // Asynchronous reset in the middle of counting
      evt[0][0] = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rvalid", {29'b0, rvalid}, 32'h0);
      chk("async_rdata0", rdata[0], 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      evt[0][0] = 1'b0;
      rd(0, 8'h00, 32'h0, "post_rst_ctrl");
      wr(8'h00, 32'h4);
      rd(0, 8'h10, 32'h0, "post_rst_nocount");
      rd(0, 8'h20, 32'h0, "post_rst_shadow2");
      wr(8'h00, 32'h1);
      pulse(0, 0, 3);
      wr(8'h00, 32'h5);
      rd(0, 8'h10, 32'h3, "post_rst_count");

`ifdef PERF_CNTR_IRQ_EN
      // Interrupt follows masked status one cycle later
      wr(8'h0C, 32'h1);
      pulse(1, 0, 255);
      evt[1][0] = 1'b1;
      tick();
      evt[1][0] = 1'b0;
      chk("irq_not_yet", {31'b0, irq[1]}, 32'h0);
      tick();
      chk("irq_rise", {31'b0, irq[1]}, 32'h1);
      wr(8'h04, 32'h1);
      chk("irq_hold", {31'b0, irq[1]}, 32'h1);
      tick();
      chk("irq_fall", {31'b0, irq[1]}, 32'h0);
      pulse(1, 3, 256);
      repeat (2) tick();
      chk("irq_masked", {31'b0, irq[1]}, 32'h0);
      rd(1, 8'h04, 32'h8, "irq_status3");
      rd(1, 8'h0C, 32'h1, "irq_mask_rd");
`else
      wr(8'h0C, 32'h1);
      rd(1, 8'h0C, 32'h0, "no_mask_reg");
`endif

      repeat (3) tick();
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Synthesizable, parametrised bank of hardware performance counters.
- Generalises the simulation-only mcycle/minstret/branch counters into NUM_CNTR independent event counters of configurable width.
- Adds freeze, clear, atomic snapshot and overflow tracking, all readable and writable over a 32-bit MMIO slave port.
- Sits beside the CPU in main. The CPU drives the event strobes; the dbus decoder drives the MMIO port.

Parameters:
- NUM_CNTR, 5, number of counters, 1..32.
- CNTR_W, 64, counter width in bits, 1..64.
- SATURATE, 0, overflow mode: 0 = wrap to 0, 1 = hold at all-ones.
- ADDR_W, 8, byte-address width of the MMIO window.

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- evt_i  in  NUM_CNTR  per-counter increment strobe, sampled each clk_i rising edge
- halt_i  in  1  global freeze (e.g. simulation/program finished); counting stops while high
- addr_i  in  ADDR_W  byte address, word aligned; bits[1:0] ignored
- wvalid_i  in  1  write strobe, one cycle per write
- wdata_i  in  32  write data
- rreq_i  in  1  read request, one cycle per read
- rdata_o  out  32  read data
- rvalid_o  out  1  read data valid
- irq_o  out  1  overflow interrupt; present only with the optional feature

Behaviour:
- Reset is asynchronous on rst_n low. All counters, shadows, CTRL, STATUS, rdata_o, rvalid_o and irq_o are cleared to 0. Reset asserted mid-operation discards everything immediately.
- Register map (byte offsets):
  - 0x00 CTRL, RW. Bit0 EN. Bit1 CLR and bit2 SNAP are self-clearing and always read 0.
  - 0x04 STATUS, RO/W1C. Bit i is the sticky overflow flag of counter i; bits ≥ NUM_CNTR read 0.
  - 0x08 INFO, RO. Value is {16'(CNTR_W), 8'(SATURATE), 8'(NUM_CNTR)}.
  - 0x10+8*i: SHADOW_LO[i]. 0x14+8*i: SHADOW_HI[i].
- Counting: counter i increments by 1 on a rising edge when EN=1, halt_i=0, evt_i[i]=1 and no CLR write occurs that cycle.
- Overflow on increment from all-ones:
  - SATURATE=0: counter wraps to 0.
  - SATURATE=1: counter holds at all-ones.
  - In both modes STATUS[i] is set in the same edge.
  - With SATURATE=1, further events while saturated do not re-set a flag already cleared by software.
- CLR write (bit1=1):
  - All counters become 0 on that edge. CLR wins over a simultaneous event.
  - STATUS is unaffected.
  - EN takes wdata_i[0] from the same write.
- SNAP write (bit2=1):
  - All shadows load the counter values as they were before this edge (pre-increment, pre-clear).
  - CLR|SNAP in one write therefore captures the old values and zeroes the live counters atomically.
- STATUS write: bits written 1 are cleared. A same-cycle overflow on the same bit wins, so the flag stays 1.
- Reads:
  - Latency 1 cycle: rreq_i at edge N gives rvalid_o=1 and rdata_o valid during cycle N+1.
  - rvalid_o is 0 otherwise; rdata_o holds its last value when rvalid_o=0.
  - Reads have no side effects.
  - SHADOW_LO returns shadow[31:0] (zero-extended if CNTR_W<32).
  - SHADOW_HI returns shadow[CNTR_W-1:32] zero-extended, or 0 if CNTR_W≤32.
  - Live counters are not directly readable; software snapshots first.
- Unmapped offsets read 0; writes to them and to INFO/SHADOW are ignored.
- Simultaneous read and write of the same address returns the pre-write value.
- Back-to-back rreq_i every cycle is supported.

Optional Feature:
- Macro: PERF_CNTR_IRQ_EN.
- Defined:
  - Adds an IRQ_MASK register at 0x0C (RW, reset 0).
  - irq_o is a register equal to |(STATUS & IRQ_MASK); it rises 1 cycle after the flag sets and falls 1 cycle after W1C.
- Undefined: no irq_o port; 0x0C reads 0 and ignores writes.

Test Plan:
- Reset, then read INFO with defaults -> rdata_o=0x0040_0005 one cycle after rreq_i; all SHADOW reads return 0.
- Write CTRL=1, pulse evt_i[2] 10 cycles with halt_i high for 3 of them, then SNAP -> SHADOW_LO[2]=7, SHADOW_HI[2]=0, other channels 0.
- CNTR_W=8, SATURATE=0: 257 events on ch0, then SNAP -> SHADOW_LO[0]=1, STATUS=0x1. Write STATUS=0x1 -> STATUS=0.
- CNTR_W=8, SATURATE=1: 300 events on ch1 -> SHADOW_LO[1]=0xFF, STATUS=0x2. CLR|SNAP write with evt_i[1]=1 that cycle -> shadow keeps 0xFF, next SNAP gives 0.
- Assert rst_n low mid-count with EN=1 -> all counters, CTRL and rvalid_o read 0 after release; no counting until EN rewritten.
- PERF_CNTR_IRQ_EN: IRQ_MASK=0x1, overflow ch0 -> irq_o=1 next cycle; W1C STATUS -> irq_o=0 next cycle; overflow ch3 (masked) -> irq_o stays 0.
